int_ctrl: RTL and testbench

- Parametrised successor of the CPU interrupt sequencer.
- Synchronises and arbitrates RESET, one edge-triggered NMI and NUM_IRQ level-triggered, individually maskable IRQ sources at instruction boundaries.
- Drives the microcode-select flags (rst/nmi/irq), the vector low byte and the active source id.
- Sits between the pins and mcode/data_mux in the k6502 core, replacing the fixed FC/FA/FE vector mux.

---
 rtl/k6502_defs.sv | 7 +
 rtl/sync_ff.sv | 27 ++
 rtl/int_ctrl.sv | 81 ++++++++
 tb/tb_int_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/k6502_defs.sv
// k6502_defs: interrupt sequencer state encodings and fixed vector low bytes.
package k6502_defs;
   typedef enum logic [1:0] {S_RST, S_IDLE, S_NMI, S_IRQ} state_t;
   localparam logic [7:0] VEC_RST = 8'hFC;
   localparam logic [7:0] VEC_NMI = 8'hFA;
   localparam logic [7:0] VEC_IRQ = 8'hFE;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage pin synchroniser that resets to all-ones (inactive for active-low pins).
module sync_ff #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   if (STAGES == 0) begin : g_bypass
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign q = d;
   end else begin : g_sync
      logic [WIDTH-1:0] ff [STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) ff[i] <= '1;
         end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
         end
      end
      assign q = ff[STAGES-1];
   end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: arbitrates RESET, edge-triggered NMI and maskable level IRQs at instruction
// boundaries, driving microcode-select flags, vector low byte and serviced source id.
module int_ctrl import k6502_defs::*; #(
   parameter int         NUM_IRQ      = 4,
   parameter int         SYNC_STAGES  = 2,
   parameter int         VECTORED     = 0,
   parameter logic [7:0] IRQ_VEC_BASE = 8'hF0
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic                                           sync,
   input  logic                                           int_done,
   input  logic                                           i_flag,
   input  logic                                           nmi_n,
   input  logic [NUM_IRQ-1:0]                             irq_n,
   input  logic [NUM_IRQ-1:0]                             irq_en,
   output logic                                           rst,
   output logic                                           nmi,
   output logic                                           irq,
   output logic [$clog2(NUM_IRQ > 1 ? NUM_IRQ : 2)-1:0]   irq_id,
   output logic [7:0]                                     vec_lo,
   output logic [NUM_IRQ-1:0]                             pending
);
   localparam int IDW = $clog2(NUM_IRQ > 1 ? NUM_IRQ : 2);

   state_t             state, state_n;
   logic               nmi_s, nmi_prev, nmi_pend, nmi_fall;
   logic [NUM_IRQ-1:0] irq_s, elig;
   logic [IDW-1:0]     win_id;
   logic               take_nmi, take_irq;

   sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_nmi (
      .clk(clk), .rst_n(rst_n), .d(nmi_n), .q(nmi_s)
   );
   sync_ff #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_sync_irq (
      .clk(clk), .rst_n(rst_n), .d(irq_n), .q(irq_s)
   );

   assign nmi_fall = nmi_prev & ~nmi_s;
   assign elig     = ~irq_s & irq_en & {NUM_IRQ{~i_flag}};
   assign pending  = elig;

   // Descending scan so the lowest eligible index wins.
   always_comb begin
      win_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (elig[i]) win_id = IDW'(i);
   end

   always_comb begin
      take_nmi = (state == S_IDLE) & sync & nmi_pend;
      take_irq = (state == S_IDLE) & sync & ~nmi_pend & (|elig);
      state_n  = state;
      state_n  = take_nmi ? S_NMI :
                 take_irq ? S_IRQ :
                 (state != S_IDLE && int_done) ? S_IDLE : state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_RST;
         nmi_prev <= 1'b1;
         nmi_pend <= 1'b0;
         irq_id   <= '0;
      end else begin
         state    <= state_n;
         nmi_prev <= nmi_s;
         // A fresh edge in the cycle NMI is taken must survive the clear.
         nmi_pend <= nmi_fall | (nmi_pend & ~take_nmi);
         if (take_irq) irq_id <= win_id;
      end
   end

   assign rst    = (state == S_RST);
   assign nmi    = (state == S_NMI);
   assign irq    = (state == S_IRQ);
   assign vec_lo = (state == S_RST) ? VEC_RST :
                   (state == S_NMI) ? VEC_NMI :
                   (state == S_IRQ && VECTORED != 0) ? IRQ_VEC_BASE - 8'({irq_id, 1'b0}) :
                   VEC_IRQ;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl, default and vectored builds on shared stimulus.
module tb_int_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, sync, int_done, i_flag, nmi_n;
   logic [3:0] irq_n, irq_en;
   logic       rst, nmi, irq, v_rst, v_nmi, v_irq;
   logic [1:0] irq_id, v_irq_id;
   logic [7:0] vec_lo, v_vec_lo;
   logic [3:0] pending, v_pending;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   int_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .sync(sync), .int_done(int_done), .i_flag(i_flag),
      .nmi_n(nmi_n), .irq_n(irq_n), .irq_en(irq_en), .rst(rst), .nmi(nmi), .irq(irq),
      .irq_id(irq_id), .vec_lo(vec_lo), .pending(pending)
   );

   int_ctrl #(.VECTORED(1), .IRQ_VEC_BASE(8'hF0)) u_vec (
      .clk(clk), .rst_n(rst_n), .sync(sync), .int_done(int_done), .i_flag(i_flag),
      .nmi_n(nmi_n), .irq_n(irq_n), .irq_en(irq_en), .rst(v_rst), .nmi(v_nmi), .irq(v_irq),
      .irq_id(v_irq_id), .vec_lo(v_vec_lo), .pending(v_pending)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_sync;
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
   endtask

   task automatic pulse_done;
      int_done = 1'b1;
      @(negedge clk);
      int_done = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; sync = 1'b0; int_done = 1'b0; i_flag = 1'b0;
      nmi_n = 1'b1; irq_n = 4'hF; irq_en = 4'hF;
      tick(3);
      checks++; if ({rst, nmi, irq} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b exp=100", {rst, nmi, irq}); end
      checks++; if (vec_lo !== 8'hFC) begin failures++; $display("FAIL reset_vec got=%h exp=fc", vec_lo); end
      checks++; if (irq_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
      checks++; if (pending !== 4'h0) begin failures++; $display("FAIL reset_pending got=%b exp=0000", pending); end
      rst_n = 1'b1;
      pulse_sync;
      checks++; if ({rst, nmi, irq} !== 3'b100) begin failures++; $display("FAIL reset_release_sync got=%b exp=100", {rst, nmi, irq}); end
      pulse_done;
      checks++; if ({rst, nmi, irq} !== 3'b000) begin failures++; $display("FAIL reset_done got=%b exp=000", {rst, nmi, irq}); end
      checks++; if (vec_lo !== 8'hFE) begin failures++; $display("FAIL idle_vec got=%h exp=fe", vec_lo); end
      pulse_sync;
      checks++; if ({rst, nmi, irq} !== 3'b000) begin failures++; $display("FAIL idle_sync got=%b exp=000", {rst, nmi, irq}); end
      pulse_done;
      checks++; if ({rst, nmi, irq} !== 3'b000) begin failures++; $display("FAIL idle_done_ignored got=%b exp=000", {rst, nmi, irq}); end
   endtask

   task automatic test_nmi_edge;
      int   nmi_cnt = 0;
      logic prev = 1'b0;
      nmi_n = 1'b0;
      for (int c = 0; c < 20; c++) begin
         sync = (c % 7 == 6);
         int_done = nmi;
         @(negedge clk);
         if (nmi && !prev) begin
            nmi_cnt++;
            checks++; if (vec_lo !== 8'hFA) begin failures++; $display("FAIL nmi_vec got=%h exp=fa", vec_lo); end
         end
         prev = nmi;
      end
      sync = 1'b0; int_done = 1'b0;
      checks++; if (nmi_cnt !== 1) begin failures++; $display("FAIL nmi_count got=%0d exp=1", nmi_cnt); end
      pulse_sync;
      checks++; if (nmi !== 1'b0) begin failures++; $display("FAIL nmi_held_low got=%b exp=0", nmi); end
      nmi_n = 1'b1;
      tick(3);
   endtask

   task automatic test_simultaneous;
      nmi_n = 1'b0; irq_n = 4'b1010;
      tick(3);
      checks++; if (pending !== 4'b0101) begin failures++; $display("FAIL sim_pending got=%b exp=0101", pending); end
      pulse_sync;
      checks++; if ({nmi, irq} !== 2'b10) begin failures++; $display("FAIL sim_nmi_first got=%b exp=10", {nmi, irq}); end
      pulse_sync;
      checks++; if ({nmi, irq} !== 2'b10) begin failures++; $display("FAIL sim_no_preempt got=%b exp=10", {nmi, irq}); end
      pulse_done;
      checks++; if ({nmi, irq} !== 2'b00) begin failures++; $display("FAIL sim_nmi_done got=%b exp=00", {nmi, irq}); end
      pulse_sync;
      checks++; if ({irq, irq_id} !== 3'b1_00) begin failures++; $display("FAIL sim_irq got=%b exp=100", {irq, irq_id}); end
      checks++; if (vec_lo !== 8'hFE) begin failures++; $display("FAIL sim_irq_vec got=%h exp=fe", vec_lo); end
      checks++; if (v_vec_lo !== 8'hF0) begin failures++; $display("FAIL sim_irq_vvec got=%h exp=f0", v_vec_lo); end
      pulse_done;
      nmi_n = 1'b1; irq_n = 4'hF;
      tick(3);
   endtask

   task automatic test_masking;
      i_flag = 1'b1; irq_n = 4'b1110;
      tick(3);
      checks++; if (pending !== 4'h0) begin failures++; $display("FAIL mask_iflag_pending got=%b exp=0000", pending); end
      pulse_sync;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_iflag_irq got=%b exp=0", irq); end
      i_flag = 1'b0; irq_en = 4'b1110;
      tick(1);
      checks++; if (pending !== 4'h0) begin failures++; $display("FAIL mask_en_pending got=%b exp=0000", pending); end
      pulse_sync;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_en_irq got=%b exp=0", irq); end
      irq_en = 4'hF;
      tick(1);
      checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL mask_open_pending got=%b exp=0001", pending); end
      pulse_sync;
      checks++; if ({irq, irq_id} !== 3'b1_00) begin failures++; $display("FAIL mask_open_irq got=%b exp=100", {irq, irq_id}); end
      pulse_done;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq_done got=%b exp=0", irq); end
      irq_n = 4'hF;
      tick(3);
   endtask

   task automatic test_vectored;
      irq_n = 4'b0111;
      tick(3);
      pulse_sync;
      checks++; if ({v_irq, v_irq_id} !== 3'b1_11) begin failures++; $display("FAIL vec_src3 got=%b exp=111", {v_irq, v_irq_id}); end
      checks++; if (v_vec_lo !== 8'hEA) begin failures++; $display("FAIL vec_src3_vec got=%h exp=ea", v_vec_lo); end
      checks++; if (vec_lo !== 8'hFE) begin failures++; $display("FAIL vec_plain_vec got=%h exp=fe", vec_lo); end
      irq_n = 4'hF;
      pulse_done;
      tick(3);
      irq_n = 4'b1011;
      tick(3);
      irq_n = 4'hF;
      tick(2);
      pulse_sync;
      checks++; if (v_irq !== 1'b0) begin failures++; $display("FAIL vec_released got=%b exp=0", v_irq); end
   endtask

   task automatic test_reset_mid;
      irq_n = 4'b1101;
      tick(3);
      pulse_sync;
      checks++; if ({irq, irq_id} !== 3'b1_01) begin failures++; $display("FAIL mid_irq got=%b exp=101", {irq, irq_id}); end
      nmi_n = 1'b0;
      tick(4);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({rst, nmi, irq} !== 3'b100) begin failures++; $display("FAIL mid_reset_flags got=%b exp=100", {rst, nmi, irq}); end
      checks++; if (vec_lo !== 8'hFC) begin failures++; $display("FAIL mid_reset_vec got=%h exp=fc", vec_lo); end
      nmi_n = 1'b1; irq_n = 4'hF;
      tick(2);
      rst_n = 1'b1;
      pulse_done;
      tick(3);
      pulse_sync;
      checks++; if ({rst, nmi, irq} !== 3'b000) begin failures++; $display("FAIL mid_nmi_discarded got=%b exp=000", {rst, nmi, irq}); end
   endtask

   initial begin
      test_reset;
      test_nmi_edge;
      test_simultaneous;
      test_masking;
      test_vectored;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
